// File: rtl/vending_pkg.sv
// Shared types and constants for the coin-return path of the vending machine.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EJECT,
        GAP
    } state_e;

    localparam int NICKEL_UNITS = 1;
    localparam int DIME_UNITS   = 2;
    localparam int MAX_CHANGE   = 4;
    localparam int CHANGE_W     = 3;

    // A change amount the hopper can pay out (0..MAX_CHANGE nickel units).
    function automatic logic change_legal(input logic [CHANGE_W-1:0] amt);
        return amt <= CHANGE_W'(MAX_CHANGE);
    endfunction

    // Greedy payout: a dime whenever at least two units remain.
    function automatic logic pick_dime(input logic [CHANGE_W-1:0] amt);
        return amt >= CHANGE_W'(DIME_UNITS);
    endfunction

endpackage

// File: rtl/change_req_buf.sv
// Single-entry holding register for a change request that arrives while a
// payout is in progress. A load in the same cycle as a take wins, so the
// buffer can hand off its entry and accept a new one at once.
module change_req_buf
    import vending_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic                take_i,
    input  logic [CHANGE_W-1:0] data_i,
    output logic                full_o,
    output logic [CHANGE_W-1:0] data_o
);

    logic                full_q;
    logic [CHANGE_W-1:0] data_q;

    // Entry valid flag and payload; load has priority over take.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (load_i) begin
            full_q <= 1'b1;
            data_q <= data_i;
        end else if (take_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/change_dispenser.sv
// Coin-return controller: pays a 0..4 nickel-unit change amount to the
// hopper as a serial dime/nickel stream under valid/ready, with GAP_CYCLES
// idle cycles after each accepted coin. One request can wait while busy.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int GAP_CYCLES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                soda_i,
    input  logic [CHANGE_W-1:0] change_i,
    input  logic                hopper_ready_i,
    output logic                nickle_o,
    output logic                dime_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    state_e              state_q;
    logic [CHANGE_W-1:0] rem_q;
    logic [GW-1:0]       gap_q;
    logic                dime_q;
    logic                nickle_q;
    logic                done_q;
    logic                err_q;

    logic                pend_full;
    logic [CHANGE_W-1:0] pend_data;

    logic                idle;
    logic                legal;
    logic                req_ok;
    logic                pend_take;
    logic                pend_load;
    logic                drop;
    logic                start_vld;
    logic [CHANGE_W-1:0] start_amt;
    logic [CHANGE_W-1:0] rem_d;

    assign idle   = (state_q == IDLE);
    assign legal  = change_legal(change_i);
    assign req_ok = soda_i & legal;

    // In IDLE a waiting request always starts first; a fresh request in the
    // same cycle takes its slot. Outside IDLE a request only fits if empty.
    assign pend_take = idle & pend_full;
    assign pend_load = req_ok & (idle ? pend_full : ~pend_full);
    assign drop      = soda_i & (~legal | (~idle & pend_full));

    assign start_vld = idle & (pend_full | req_ok);
    assign start_amt = pend_full ? pend_data : change_i;

    // Remaining amount after the presented coin is taken.
    assign rem_d = rem_q - (dime_q ? CHANGE_W'(DIME_UNITS) : CHANGE_W'(NICKEL_UNITS));

    change_req_buf u_buf (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (pend_load),
        .take_i (pend_take),
        .data_i (change_i),
        .full_o (pend_full),
        .data_o (pend_data)
    );

    // Payout FSM with registered coin/done/err outputs and the gap counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            gap_q    <= '0;
            dime_q   <= 1'b0;
            nickle_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (drop) err_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (start_vld) begin
                        rem_q <= start_amt;
                        if (start_amt == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q  <= EJECT;
                            dime_q   <= pick_dime(start_amt);
                            nickle_q <= ~pick_dime(start_amt);
                        end
                    end
                end
                EJECT: begin
                    if (hopper_ready_i) begin
                        rem_q    <= rem_d;
                        dime_q   <= 1'b0;
                        nickle_q <= 1'b0;
                        if (rem_d == '0) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else if (GAP_CYCLES == 0) begin
                            dime_q   <= pick_dime(rem_d);
                            nickle_q <= ~pick_dime(rem_d);
                        end else begin
                            state_q <= GAP;
                            gap_q   <= GW'(GAP_CYCLES);
                        end
                    end
                end
                GAP: begin
                    if (gap_q <= GW'(1)) begin
                        state_q  <= EJECT;
                        dime_q   <= pick_dime(rem_q);
                        nickle_q <= ~pick_dime(rem_q);
                    end else begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dime_o   = dime_q;
    assign nickle_o = nickle_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign busy_o   = ~idle | pend_full;

endmodule
